// File: rtl/mmio_axil_id_tracker.sv
// mmio_axil_id_tracker
//   Bridges an ID-carrying host MMIO AXI-lite port onto an ID-less AXI-lite
//   slave. AR/AW IDs are held in per-direction in-order FIFOs and returned
//   on R/B. All channel signals pass through combinationally, so no cycles
//   are added. New address handshakes are refused while DEPTH transactions
//   are outstanding in that direction.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   s_ar*/s_r*/s_aw*/s_w*/s_b*   host side (with IDs, ADDR_IN_W addresses)
//   m_ar*/m_r*/m_aw*/m_w*/m_b*   slave side (no IDs, ADDR_OUT_W addresses)
//   rd_outstanding/wr_outstanding  current ID FIFO occupancy
//   err_clr                      clears the sticky orphan flags
//   err_rd_orphan/err_wr_orphan  sticky orphan-response flags
//
// Build option: define MMIO_ID_TRACK_ERR_EN to flag responses that arrive
// with nothing outstanding. Such a response is forwarded with ID 0 and
// SLVERR. Without the macro the flags are tied to 0 and the response is
// forwarded unmodified, carrying whatever ID is left at the FIFO head.

module mmio_axil_id_fifo #(
    parameter int ID_W  = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [ID_W-1:0]          push_id,
    input  logic                     pop,
    output logic [ID_W-1:0]          head_id,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    // Full/empty come from the registered count only. A pop in the same
    // cycle therefore never lets a push through.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head_id = mem[rptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= push_id;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end
endmodule

module mmio_axil_id_tracker #(
    parameter int ID_W       = 9,
    parameter int ADDR_IN_W  = 18,
    parameter int ADDR_OUT_W = 32,
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    // host read
    input  logic                    s_arvalid,
    output logic                    s_arready,
    input  logic [ADDR_IN_W-1:0]    s_araddr,
    input  logic [ID_W-1:0]         s_arid,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [DATA_W-1:0]       s_rdata,
    output logic [1:0]              s_rresp,
    output logic [ID_W-1:0]         s_rid,
    // host write
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [ADDR_IN_W-1:0]    s_awaddr,
    input  logic [ID_W-1:0]         s_awid,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    input  logic [DATA_W-1:0]       s_wdata,
    input  logic [DATA_W/8-1:0]     s_wstrb,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    output logic [1:0]              s_bresp,
    output logic [ID_W-1:0]         s_bid,
    // slave read
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [ADDR_OUT_W-1:0]   m_araddr,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [DATA_W-1:0]       m_rdata,
    input  logic [1:0]              m_rresp,
    // slave write
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [ADDR_OUT_W-1:0]   m_awaddr,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic [DATA_W-1:0]       m_wdata,
    output logic [DATA_W/8-1:0]     m_wstrb,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    input  logic [1:0]              m_bresp,
    // status
    output logic [$clog2(DEPTH):0]  rd_outstanding,
    output logic [$clog2(DEPTH):0]  wr_outstanding,
    input  logic                    err_clr,
    output logic                    err_rd_orphan,
    output logic                    err_wr_orphan
);
    logic            rd_full, rd_empty, rd_push, rd_pop;
    logic            wr_full, wr_empty, wr_push, wr_pop;
    logic [ID_W-1:0] rd_head, wr_head;

    assign m_arvalid = s_arvalid & ~rd_full;
    assign s_arready = m_arready & ~rd_full;
    assign m_araddr  = ADDR_OUT_W'(s_araddr);
    assign rd_push   = s_arvalid & m_arready & ~rd_full;

    assign s_rvalid  = m_rvalid;
    assign m_rready  = s_rready;
    assign s_rdata   = m_rdata;
    // A response with nothing outstanding never moves the read pointer.
    assign rd_pop    = m_rvalid & s_rready & ~rd_empty;

    assign m_awvalid = s_awvalid & ~wr_full;
    assign s_awready = m_awready & ~wr_full;
    assign m_awaddr  = ADDR_OUT_W'(s_awaddr);
    assign wr_push   = s_awvalid & m_awready & ~wr_full;

    // W is independent of AW ordering and is never gated.
    assign m_wvalid  = s_wvalid;
    assign s_wready  = m_wready;
    assign m_wdata   = s_wdata;
    assign m_wstrb   = s_wstrb;

    assign s_bvalid  = m_bvalid;
    assign m_bready  = s_bready;
    assign wr_pop    = m_bvalid & s_bready & ~wr_empty;

    mmio_axil_id_fifo #(.ID_W(ID_W), .DEPTH(DEPTH)) u_rd_fifo (
        .clk(clk), .reset_n(reset_n), .push(rd_push), .push_id(s_arid),
        .pop(rd_pop), .head_id(rd_head), .count(rd_outstanding),
        .full(rd_full), .empty(rd_empty)
    );

    mmio_axil_id_fifo #(.ID_W(ID_W), .DEPTH(DEPTH)) u_wr_fifo (
        .clk(clk), .reset_n(reset_n), .push(wr_push), .push_id(s_awid),
        .pop(wr_pop), .head_id(wr_head), .count(wr_outstanding),
        .full(wr_full), .empty(wr_empty)
    );

`ifdef MMIO_ID_TRACK_ERR_EN
    logic rd_orphan, wr_orphan;

    assign rd_orphan = m_rvalid & rd_empty;
    assign wr_orphan = m_bvalid & wr_empty;
    assign s_rid     = rd_orphan ? '0 : rd_head;
    assign s_rresp   = rd_orphan ? 2'b10 : m_rresp;
    assign s_bid     = wr_orphan ? '0 : wr_head;
    assign s_bresp   = wr_orphan ? 2'b10 : m_bresp;

    // A new orphan in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_rd_orphan <= 1'b0;
            err_wr_orphan <= 1'b0;
        end else begin
            if (rd_orphan)    err_rd_orphan <= 1'b1;
            else if (err_clr) err_rd_orphan <= 1'b0;
            if (wr_orphan)    err_wr_orphan <= 1'b1;
            else if (err_clr) err_wr_orphan <= 1'b0;
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign s_rid          = rd_head;
    assign s_rresp        = m_rresp;
    assign s_bid          = wr_head;
    assign s_bresp        = m_bresp;
    assign err_rd_orphan  = 1'b0;
    assign err_wr_orphan  = 1'b0;
`endif
endmodule

// File: doc/mmio_axil_id_tracker.md
Name: mmio_axil_id_tracker

Overview:
- Sits between the host MMIO AXI-lite channel (carries transaction IDs) and the ID-less Fletcher top-level AXI-lite slave.
- Captures AR/AW IDs in per-direction in-order FIFOs and returns them on R/B.
- Bounds outstanding transactions and zero-extends MMIO addresses to the slave bus width.
- Parametrised in ID width, address widths, data width and tracking depth.

Parameters:
- ID_W, 9, MMIO transaction ID width.
- ADDR_IN_W, 18, host-side address width.
- ADDR_OUT_W, 32, slave-side address width; must be >= ADDR_IN_W.
- DATA_W, 64, data width; strobe width is DATA_W/8.
- DEPTH, 4, per-direction ID FIFO depth; power of two, >= 2.

Ports:
- clk  in  1  Single clock for all logic.
- reset_n  in  1  Synchronous, active-low reset.
- s_arvalid/s_arready  in/out  1/1  Host read-address handshake.
- s_araddr/s_arid  in  ADDR_IN_W/ID_W  Host read address and read ID.
- s_rvalid/s_rready  out/in  1/1  Host read-data handshake.
- s_rdata/s_rresp/s_rid  out  DATA_W/2/ID_W  Host read data, response and returned ID.
- s_awvalid/s_awready  in/out  1/1  Host write-address handshake.
- s_awaddr/s_awid  in  ADDR_IN_W/ID_W  Host write address and write ID.
- s_wvalid/s_wready  in/out  1/1  Host write-data handshake.
- s_wdata/s_wstrb  in  DATA_W/DATA_W/8  Host write data and strobes.
- s_bvalid/s_bready  out/in  1/1  Host write-response handshake.
- s_bresp/s_bid  out  2/ID_W  Host write response and returned ID.
- m_* (ar, r, aw, w, b)  mirrored  —  Slave-side AXI-lite, same signals without IDs; addresses are ADDR_OUT_W.
- rd_outstanding/wr_outstanding  out  $clog2(DEPTH)+1  Current FIFO occupancy per direction.
- err_clr  in  1  Clears sticky error flags.
- err_rd_orphan/err_wr_orphan  out  1  Sticky orphan-response flags.

Behaviour:
- Reset (reset_n=0 at a clk edge): FIFO pointers, storage, counts and error flags cleared to 0. s_rid/s_bid read 0. Valid and ready outputs follow the combinational rules below with FIFOs empty.
- AR path (combinational):
  - m_arvalid = s_arvalid & ~rd_full.
  - s_arready = m_arready & ~rd_full.
  - m_araddr = zero-extended s_araddr.
- AR handshake pushes s_arid.
- Full is evaluated on registered count; a pop in the same cycle does not unblock a push (no bypass).
- R path (combinational pass-through of rvalid/rready/rdata/rresp):
  - s_rid = head of read FIFO.
  - Pop on s_rvalid & s_rready.
- AW/W/B: mirror of AR/R.
  - AW gated by wr_full; W passes through ungated and independently of AW ordering.
  - s_bid = write FIFO head; pop on B handshake.
- Latency:
  - Zero added cycles on all channels.
  - A pushed ID is visible at the head on the cycle after its push.
  - The slave must not respond in the same cycle as the accepting address handshake.
- Push and pop in the same cycle while not full: count unchanged; pointers both advance and wrap modulo DEPTH.
- Responses are strictly in order; no reordering.
- Reset mid-operation: all tracking is discarded. Responses that arrive later are orphans.

Optional Feature:
- Macro: MMIO_ID_TRACK_ERR_EN.
- Defined:
  - m_rvalid with the read FIFO empty sets err_rd_orphan (sticky). That response is forwarded with s_rid=0 and s_rresp forced to 2'b10, and is not a pop.
  - Write side identical, using err_wr_orphan.
  - err_clr clears the flags on the next edge; a same-cycle set wins over clear.
- Undefined:
  - err_* are tied to 0.
  - Orphans are forwarded unmodified with the stale head ID, and no pointer moves.

Test Plan:
- Single read: AR id 0x1A3, addr 0x00040 -> m_araddr 0x00000040; R returns rid 0x1A3; rd_outstanding goes 0->1->0.
- Read backpressure: m_arready=1, slave R held off, ARs with ids 1..5 -> 5th AR sees s_arready=0 until the first R handshake; R ids 1,2,3,4,5 in order.
- Concurrent push/pop at occupancy 2: simultaneous AR and R handshake -> rd_outstanding stays 2; pointers wrap after 4+ transactions with ids intact.
- Write: W accepted before AW (id 0x055, strb 0xFF), then B -> bid 0x055, wr_outstanding returns to 0; m_awaddr zero-extended.
- With MMIO_ID_TRACK_ERR_EN: m_rvalid while empty -> err_rd_orphan=1, s_rresp=2'b10, s_rid=0; err_clr pulse -> flag 0 on the next cycle.
- Reset mid-flight: 3 reads outstanding, reset_n low for 1 cycle -> rd_outstanding=0, s_rid=0, s_arready=m_arready on the next cycle.
